// File: rtl/mac_sched_pkg.sv
// Shared types and constants for the MAC transmit scheduler.
// The descriptor struct matches the generator's configuration inputs field for field.
package mac_sched_pkg;

  localparam int ETH_MAX_PAYLOAD = 1500;
  localparam int DESC_W          = 128;

  typedef enum logic [1:0] {
    IDLE,
    START,
    TX,
    IFG
  } sched_state_t;

  typedef struct packed {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] eth_type;
    logic [15:0] len;
  } frame_desc_t;

  // A zero-length or oversize payload is never handed to the generator.
  function automatic logic len_ok(input logic [15:0] len, input int max_len);
    return (len != 16'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 found_o
);

  localparam int IDX_W = $clog2(N);

  always_comb begin
    // NOTE: outputs get a value before the loop so no path leaves them unassigned (no latch).
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found_o && req_i[(int'(ptr_i) + i) % N]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'((int'(ptr_i) + i) % N);
      end
    end
  end

endmodule

// File: rtl/mac_tx_scheduler.sv
// Round-robin transmit scheduler sharing one mac_mii_top generator among N_REQ sources.
// Sequences grant -> start -> frame -> inter-frame gap; every output is a register.
module mac_tx_scheduler
  import mac_sched_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int MAX_PAYLOAD   = ETH_MAX_PAYLOAD,
  parameter int IFG_CYCLES    = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*48-1:0]      i_req_dest,
  input  logic [N_REQ*48-1:0]      i_req_src,
  input  logic [N_REQ*16-1:0]      i_req_eth_type,
  input  logic [N_REQ*16-1:0]      i_req_len,
  input  logic                     i_pause,
  input  logic                     i_tx_valid,
  output logic                     o_start,
  output logic [47:0]              o_dest_address,
  output logic [47:0]              o_src_address,
  output logic [15:0]              o_eth_type,
  output logic [15:0]              o_payload_length,
  output logic [$clog2(N_REQ)-1:0] o_payload_sel,
  output logic [N_REQ-1:0]         o_grant,
  output logic [N_REQ-1:0]         o_done,
  output logic [N_REQ-1:0]         o_err,
  output logic                     o_busy
);

  localparam int SEL_W   = $clog2(N_REQ);
  localparam int CNT_MAX = (START_TIMEOUT > IFG_CYCLES) ? START_TIMEOUT : IFG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  sched_state_t     state_q, state_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  frame_desc_t      desc_q, desc_d;
  logic             start_q, start_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] err_q, err_d;

  logic [SEL_W-1:0] win;
  logic             found;
  int               win_i;
  frame_desc_t      win_desc;
  logic [SEL_W-1:0] ptr_after_win;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i   (i_req),
    .ptr_i   (rr_ptr_q),
    .idx_o   (win),
    .found_o (found)
  );

  assign win_i         = int'(win);
  assign ptr_after_win = (win == SEL_W'(N_REQ - 1)) ? '0 : win + 1'b1;
  assign win_desc      = '{dest:     i_req_dest[win_i*48 +: 48],
                           src:      i_req_src[win_i*48 +: 48],
                           eth_type: i_req_eth_type[win_i*16 +: 16],
                           len:      i_req_len[win_i*16 +: 16]};

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    desc_d   = desc_q;
    start_d  = start_q;
    grant_d  = '0;
    done_d   = '0;
    err_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (!i_pause && found) begin
          rr_ptr_d = ptr_after_win;
          if (!len_ok(win_desc.len, MAX_PAYLOAD)) begin
            err_d[win] = 1'b1;
          end else begin
            desc_d       = win_desc;
            sel_d        = win;
            grant_d[win] = 1'b1;
            start_d      = 1'b1;
            cnt_d        = '0;
            state_d      = START;
          end
        end
      end
      START: begin
        if (i_tx_valid) begin
          start_d = 1'b0;
          state_d = TX;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          start_d      = 1'b0;
          err_d[sel_q] = 1'b1;
          cnt_d        = '0;
          state_d      = IFG;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX: begin
        // Frames of any length are waited out; only the falling edge of valid ends TX.
        if (!i_tx_valid) begin
          done_d[sel_q] = 1'b1;
          cnt_d         = '0;
          state_d       = IFG;
        end
      end
      IFG: begin
        if (int'(cnt_q) + 1 >= IFG_CYCLES) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the descriptor registers are reset too, so the generator never sees stale config.
    if (!i_rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      desc_q   <= '0;
      start_q  <= 1'b0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register reading pre-edge values.
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      desc_q   <= desc_d;
      start_q  <= start_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_start          = start_q;
  assign o_dest_address   = desc_q.dest;
  assign o_src_address    = desc_q.src;
  assign o_eth_type       = desc_q.eth_type;
  assign o_payload_length = desc_q.len;
  assign o_payload_sel    = sel_q;
  assign o_grant          = grant_q;
  assign o_done           = done_q;
  assign o_err            = err_q;
  assign o_busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mac_tx_scheduler.sv
// Self-checking bench: timestamp-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mac_tx_scheduler;

  localparam int N    = 4;
  localparam int MAXP = 1500;
  localparam int IFGC = 2;
  localparam int TMO  = 16;

  localparam int PH_IDLE = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_SEND = 2;
  localparam int PH_GAP  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic [N-1:0]  req   = '0;
  logic          pause = 1'b0;
  logic          txv   = 1'b0;
  logic [47:0]   t_dest [N];
  logic [47:0]   t_src  [N];
  logic [15:0]   t_type [N];
  logic [15:0]   t_len  [N];
  logic [N*48-1:0] dest_f, src_f;
  logic [N*16-1:0] type_f, len_f;

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign dest_f[k*48 +: 48] = t_dest[k];
    assign src_f[k*48 +: 48]  = t_src[k];
    assign type_f[k*16 +: 16] = t_type[k];
    assign len_f[k*16 +: 16]  = t_len[k];
  end

  logic         start, busy;
  logic [47:0]  dest_o, src_o;
  logic [15:0]  type_o, len_o;
  logic [1:0]   sel;
  logic [N-1:0] grant, done, err;

  mac_tx_scheduler #(
    .N_REQ(N), .MAX_PAYLOAD(MAXP), .IFG_CYCLES(IFGC), .START_TIMEOUT(TMO)
  ) dut (
    .clk              (clk),
    .i_rst_n          (rst_n),
    .i_req            (req),
    .i_req_dest       (dest_f),
    .i_req_src        (src_f),
    .i_req_eth_type   (type_f),
    .i_req_len        (len_f),
    .i_pause          (pause),
    .i_tx_valid       (txv),
    .o_start          (start),
    .o_dest_address   (dest_o),
    .o_src_address    (src_o),
    .o_eth_type       (type_o),
    .o_payload_length (len_o),
    .o_payload_sel    (sel),
    .o_grant          (grant),
    .o_done           (done),
    .o_err            (err),
    .o_busy           (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: phases plus absolute edge timestamps.
  int cyc = 0;
  int phase = PH_IDLE;
  int owner = 0;
  int ptr = 0;
  int t_mark = 0;
  int m_k, m_j;
  bit prev_txv = 1'b0;
  int txv_rise_cyc = 0;
  int txv_fall_cyc = 0;
  logic         exp_start = 1'b0, exp_busy = 1'b0;
  logic [N-1:0] exp_grant = '0, exp_done = '0, exp_err = '0;
  logic [1:0]   exp_sel = '0;
  logic [47:0]  exp_dest = '0, exp_src = '0;
  logic [15:0]  exp_type = '0, exp_len = '0;

  always @(posedge clk) begin
    cyc++;
    if (txv && !prev_txv) txv_rise_cyc = cyc;
    if (!txv && prev_txv) txv_fall_cyc = cyc;
    prev_txv  = txv;
    exp_grant = '0;
    exp_done  = '0;
    exp_err   = '0;
    if (!rst_n) begin
      phase = PH_IDLE; ptr = 0; exp_start = 1'b0; exp_sel = '0;
      exp_dest = '0; exp_src = '0; exp_type = '0; exp_len = '0;
    end else begin
      case (phase)
        PH_IDLE: if (!pause && req != '0) begin
          m_k = -1;
          for (int i = 0; i < N; i++) begin
            m_j = (ptr + i) % N;
            if (m_k < 0 && req[m_j]) m_k = m_j;
          end
          ptr = (m_k + 1) % N;
          if (t_len[m_k] == 0 || int'(t_len[m_k]) > MAXP) begin
            exp_err[m_k] = 1'b1;
          end else begin
            owner = m_k; exp_grant[m_k] = 1'b1; exp_start = 1'b1;
            exp_sel = 2'(m_k); exp_dest = t_dest[m_k]; exp_src = t_src[m_k];
            exp_type = t_type[m_k]; exp_len = t_len[m_k];
            t_mark = cyc; phase = PH_WAIT;
          end
        end
        PH_WAIT: if (txv) begin
          exp_start = 1'b0; phase = PH_SEND;
        end else if (cyc - t_mark == TMO) begin
          exp_start = 1'b0; exp_err[owner] = 1'b1; t_mark = cyc; phase = PH_GAP;
        end
        PH_SEND: if (!txv) begin
          exp_done[owner] = 1'b1; t_mark = cyc; phase = PH_GAP;
        end
        default: if (cyc - t_mark >= IFGC) phase = PH_IDLE;
      endcase
    end
    exp_busy = (phase != PH_IDLE);
  end

  // Compare process and event logs (sampled 1 time unit after the edge).
  int g_idx[$], g_cyc[$], d_idx[$], d_cyc[$], e_idx[$], e_cyc[$];
  int start_hi_cnt = 0;
  int start_fall_cyc = 0;
  logic prev_start = 1'b0;

  function automatic int oh2i(input logic [N-1:0] v);
    int r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    check("grant", grant, exp_grant);
    check("done", done, exp_done);
    check("err", err, exp_err);
    check("start", start, exp_start);
    check("busy", busy, exp_busy);
    check("sel", sel, exp_sel);
    check("dest", dest_o, exp_dest);
    check("src", src_o, exp_src);
    check("eth_type", type_o, exp_type);
    check("len", len_o, exp_len);
    if (grant != '0) begin g_idx.push_back(oh2i(grant)); g_cyc.push_back(cyc); end
    if (done != '0) begin d_idx.push_back(oh2i(done)); d_cyc.push_back(cyc); end
    if (err != '0) begin e_idx.push_back(oh2i(err)); e_cyc.push_back(cyc); end
    if (grant != '0) start_hi_cnt = start ? 1 : 0;
    else if (start) start_hi_cnt++;
    if (prev_start && !start) start_fall_cyc = cyc;
    prev_start = start;
  end

  // Generator model: raise valid gen_delay cycles after start, hold it gen_len cycles.
  bit gen_en = 1'b0;
  int gen_delay = 3;
  int gen_len = 10;

  initial begin
    forever begin
      @(negedge clk);
      if (gen_en && start) begin
        repeat (gen_delay - 1) @(negedge clk);
        txv = 1'b1;
        repeat (gen_len) @(negedge clk);
        txv = 1'b0;
      end
    end
  end

  task automatic wait_log(input string name, input int which, input int target, input int limit);
    bit ok = 1'b0;
    int n;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      n = (which == 0) ? g_idx.size() : (which == 1) ? d_idx.size() : e_idx.size();
      if (n >= target) ok = 1'b1;
    end
    check({name, "_timeout"}, ok, 1);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!busy && !txv) ok = 1'b1;
    end
    check({name, "_idle_timeout"}, ok, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_txv(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (txv) ok = 1'b1;
    end
    check({name, "_txv_timeout"}, ok, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int base, rel, nb;
  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int k = 0; k < N; k++) begin
      t_dest[k] = 48'h0200_0000_0010 + 48'(k);
      t_src[k]  = 48'h0200_0000_0A00 + 48'(k);
      t_type[k] = 16'h0800 + 16'(k);
      t_len[k]  = 16'(64 + 50 * k);
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_len", len_o, 0);
    check("rst_sel", sel, 0);
    rst_n = 1'b1;

    // Single request from requester 1.
    gen_en = 1'b1; gen_delay = 3; gen_len = 10; t_len[1] = 16'd49;
    req[1] = 1'b1;
    wait_log("single_grant", 0, 1, 5);
    check("single_grant_vec", grant, 4'b0010);
    check("single_len", len_o, 49);
    check("single_sel", sel, 1);
    check("single_start", start, 1);
    req[1] = 1'b0;
    req[2] = 1'b1;
    wait_log("single_done", 1, 1, 30);
    check("single_done_vec", done, 4'b0010);
    check("single_done_edge", d_cyc[0], txv_fall_cyc);
    check("single_start_fall", start_fall_cyc, txv_rise_cyc);
    wait_log("single_next", 0, 2, 10);
    check("single_next_idx", g_idx[1], 2);
    check("single_ifg_gap", g_cyc[1] - txv_fall_cyc, IFGC + 1);
    check("single_done_once", d_idx.size(), 1);
    req[2] = 1'b0;
    wait_idle("single");

    // Round-robin fairness from a fresh pointer.
    do_reset();
    gen_delay = 2; gen_len = 3;
    base = g_idx.size();
    req = 4'b1111;
    wait_log("rr", 0, base + 5, 200);
    req = '0;
    for (int i = 0; i < 5; i++) begin
      check("rr_order", g_idx[base + i], order[i]);
      if (i > 0) check("rr_no_repeat", g_idx[base + i] != g_idx[base + i - 1], 1);
    end
    wait_idle("rr");

    // Length rejection at the boundaries.
    t_len[2] = 16'd0;
    base = e_idx.size();
    req[2] = 1'b1;
    wait_log("len0", 2, base + 1, 5);
    check("len0_err", err, 4'b0100);
    check("len0_start", start, 0);
    req[2] = 1'b0;
    repeat (2) @(negedge clk);
    t_len[2] = 16'd1501;
    req[2] = 1'b1;
    wait_log("len1501", 2, base + 2, 5);
    check("len1501_err", err, 4'b0100);
    check("len1501_start", start, 0);
    req[2] = 1'b0;
    repeat (2) @(negedge clk);
    t_len[2] = 16'd1500;
    base = g_idx.size();
    req[2] = 1'b1;
    wait_log("len1500", 0, base + 1, 5);
    check("len1500_grant", grant, 4'b0100);
    check("len1500_len", len_o, 1500);
    req[2] = 1'b0;
    wait_idle("len1500");

    // Start timeout with a silent generator.
    gen_en = 1'b0;
    base = e_idx.size();
    req[3] = 1'b1;
    wait_log("tmo_grant", 0, g_idx.size() + 1, 5);
    req[3] = 1'b0;
    wait_log("tmo_err", 2, base + 1, 25);
    check("tmo_err_vec", err, 4'b1000);
    check("tmo_start_cycles", start_hi_cnt, 16);
    check("tmo_err_delay", e_cyc[e_cyc.size() - 1] - g_cyc[g_cyc.size() - 1], 16);
    nb = 0;
    while (busy && nb < 10) begin nb++; @(negedge clk); end
    check("tmo_ifg_cycles", nb, IFGC);
    gen_en = 1'b1;
    repeat (2) @(negedge clk);

    // Pause during TX: the frame completes, then no grant until release.
    gen_delay = 2; gen_len = 6;
    base = g_idx.size();
    req = 4'b0011;
    wait_log("pause_grant", 0, base + 1, 5);
    check("pause_first_idx", g_idx[base], 0);
    req[0] = 1'b0;
    wait_txv("pause");
    pause = 1'b1;
    wait_log("pause_done", 1, d_idx.size() + 1, 20);
    check("pause_done_idx", d_idx[d_idx.size() - 1], 0);
    base = g_idx.size();
    repeat (10) @(negedge clk);
    check("pause_no_grant", g_idx.size(), base);
    check("pause_idle", busy, 0);
    pause = 1'b0;
    rel = cyc + 1;
    wait_log("pause_release", 0, base + 1, 5);
    check("pause_release_idx", g_idx[base], 1);
    check("pause_release_edge", g_cyc[base], rel);
    req[1] = 1'b0;
    wait_idle("pause");

    // Reset in the middle of a frame.
    gen_delay = 2; gen_len = 10;
    base = g_idx.size();
    req = 4'b1010;
    wait_log("mid_grant", 0, base + 1, 5);
    check("mid_first_idx", g_idx[base], 3);
    req[3] = 1'b0;
    wait_txv("mid");
    repeat (2) @(negedge clk);
    nb = d_idx.size();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_start", start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_len", len_o, 0);
    check("mid_rst_dest", dest_o, 0);
    check("mid_rst_sel", sel, 0);
    rst_n = 1'b1;
    wait_log("mid_post_grant", 0, base + 2, 5);
    check("mid_post_idx", g_idx[base + 1], 1);
    req[1] = 1'b0;
    wait_log("mid_post_done", 1, nb + 1, 30);
    check("mid_done_owner", d_idx[nb], 1);
    wait_idle("mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
